// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter:
// FSM states, transaction owner and address alignment helpers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } stateT;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } ownerT;

  localparam logic [63:0] ALIGN_MASK = 64'h7;
  localparam int          CNT_W      = 3;
  localparam int          STARVE_W   = 4;

  function automatic logic isMisaligned(input logic [63:0] addr);
    return (addr & ALIGN_MASK) != 64'd0;
  endfunction

  function automatic logic [63:0] alignAddr(input logic [63:0] addr);
    return addr & ~ALIGN_MASK;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface mem_port_arbiter_if;
  // Handshake: a requester raises *_req with stable address/data and holds it
  // until the one-cycle *_ack; *_valid pulses once per read with *_rdata
  // valid in that cycle; d_err replaces the access for a misaligned request.
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ack;
  logic        if_valid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_ack;
  logic        d_valid;
  logic [63:0] d_rdata;
  logic        d_err;

  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_wr;
  logic [63:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_valid, if_rdata, d_ack, d_valid, d_rdata, d_err,
           mem_addr, mem_wdata, mem_wr
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_valid, if_rdata, d_ack, d_valid, d_rdata, d_err,
           mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/mem_port_arbiter_select.sv
// Winner selection between fetch and data, misalignment check and the
// fetch anti-starvation counter.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                arbEn,
  input  logic                ifReq,
  input  logic                dReq,
  input  logic [63:0]         dAddr,
  output logic                grantIf,
  output logic                grantD,
  output logic                dMisaligned,
  output logic [STARVE_W-1:0] starveCnt
);

  logic forceIf;

  always_comb begin
    forceIf     = ifReq && (starveCnt == STARVE_W'(STARVE_MAX));
    grantD      = dReq && !forceIf;
    grantIf     = ifReq && (!dReq || forceIf);
    dMisaligned = grantD && isMisaligned(dAddr);
  end

  // Only arbitration edges move the counter; a rejected misaligned data
  // request still counts as a data grant.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      starveCnt <= '0;
    end else if (arbEn) begin
      if (!ifReq || grantIf) begin
        starveCnt <= '0;
      end else if (grantD && (starveCnt != STARVE_W'(STARVE_MAX))) begin
        starveCnt <= starveCnt + STARVE_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and data access,
// one transaction in flight, data-first with fetch anti-starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                Reset,
  mem_port_arbiter_if.slave   bus,
  output stateT               dbgState,
  output logic [STARVE_W-1:0] dbgStarveCnt
);

  stateT             state;
  stateT             stateNext;
  ownerT             owner;
  logic              weReg;
  logic              misReg;
  logic              wordHi;
  logic [63:0]       wdataReg;
  logic [63:0]       memAddrReg;
  logic [CNT_W-1:0]  latCnt;
  logic [31:0]       ifRdataReg;
  logic [63:0]       dRdataReg;
  logic              arbEn;
  logic              grantIf;
  logic              grantD;
  logic              dMisaligned;

  assign arbEn = (state == IDLE);

  mem_arb_select #(
    .STARVE_MAX(STARVE_MAX)
  ) u_select (
    .clk        (clk),
    .Reset      (Reset),
    .arbEn      (arbEn),
    .ifReq      (bus.if_req),
    .dReq       (bus.d_req),
    .dAddr      (bus.d_addr),
    .grantIf    (grantIf),
    .grantD     (grantD),
    .dMisaligned(dMisaligned),
    .starveCnt  (dbgStarveCnt)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Strobes decode straight from registered state so an asynchronous reset
  // clears them (mem_wr included) without waiting for a clock.
  always_comb begin
    stateNext     = state;
    bus.if_ack    = 1'b0;
    bus.if_valid  = 1'b0;
    bus.d_ack     = 1'b0;
    bus.d_valid   = 1'b0;
    bus.d_err     = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: begin
        if (grantIf || grantD) begin
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        bus.if_ack = (owner == OWN_IF);
        bus.d_ack  = (owner == OWN_D);
        bus.d_err  = (owner == OWN_D) && misReg;
        bus.mem_wr = (owner == OWN_D) && weReg && !misReg;
        if (bus.mem_wr) begin
          bus.mem_wdata = wdataReg;
        end
        if ((owner == OWN_D) && (weReg || misReg)) begin
          stateNext = IDLE;
        end else begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (latCnt == CNT_W'(1)) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        bus.if_valid = (owner == OWN_IF);
        bus.d_valid  = (owner == OWN_D);
        stateNext    = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      owner      <= OWN_IF;
      weReg      <= 1'b0;
      misReg     <= 1'b0;
      wordHi     <= 1'b0;
      wdataReg   <= '0;
      memAddrReg <= '0;
      latCnt     <= '0;
      ifRdataReg <= '0;
      dRdataReg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantIf) begin
            owner      <= OWN_IF;
            weReg      <= 1'b0;
            misReg     <= 1'b0;
            wordHi     <= bus.if_addr[2];
            memAddrReg <= alignAddr(bus.if_addr);
          end else if (grantD) begin
            owner    <= OWN_D;
            weReg    <= bus.d_we;
            misReg   <= dMisaligned;
            wdataReg <= bus.d_wdata;
            // A misaligned request never reaches the memory address bus.
            if (!dMisaligned) begin
              memAddrReg <= alignAddr(bus.d_addr);
            end
          end
        end
        ISSUE: begin
          latCnt <= CNT_W'(MEM_LAT);
        end
        WAIT: begin
          latCnt <= latCnt - CNT_W'(1);
          if (latCnt == CNT_W'(1)) begin
            if (owner == OWN_IF) begin
              ifRdataReg <= wordHi ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
            end else begin
              dRdataReg <= bus.mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr = memAddrReg;
  assign bus.if_rdata = ifRdataReg;
  assign bus.d_rdata  = dRdataReg;
  assign dbgState     = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: latency-accurate memory model, reference
// memory with an expected-read queue, grant-order model and reset aborts.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int MEM_LAT    = 3;
  localparam int STARVE_MAX = 4;
  localparam int W          = 64;
  localparam int WORDS      = 128;

  logic        clk;
  logic        Reset;
  stateT       dbgState;
  logic [3:0]  dbgStarveCnt;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .bus         (bus),
    .dbgState    (dbgState),
    .dbgStarveCnt(dbgStarveCnt)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory with MEM_LAT read latency ----------------
  function automatic logic [63:0] seedWord(input int i);
    logic [31:0] k;
    k = 32'(i);
    return {k * 32'h9E37_79B9, k ^ 32'h5A5A_0F0F};
  endfunction

  logic [63:0] memArr [WORDS];
  logic [63:0] rdPipe [MEM_LAT];
  logic        memLoaded = 1'b0;

  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < WORDS; i++) memArr[i] <= seedWord(i);
      memLoaded <= 1'b1;
    end else if (bus.mem_wr) begin
      memArr[bus.mem_addr[9:3]] <= bus.mem_wdata;
    end
    rdPipe[0] <= memArr[bus.mem_addr[9:3]];
    for (int i = 1; i < MEM_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end

  assign bus.mem_rdata = rdPipe[MEM_LAT-1];

  // ---------------- activity monitor ----------------
  int ifAckCnt = 0, ifValidCnt = 0, dAckCnt = 0, dValidCnt = 0, memWrCnt = 0;

  always @(posedge clk) begin
    if (bus.if_ack)   ifAckCnt++;
    if (bus.if_valid) ifValidCnt++;
    if (bus.d_ack)    dAckCnt++;
    if (bus.d_valid)  dValidCnt++;
    if (bus.mem_wr)   memWrCnt++;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [63:0]  refMem [WORDS];
  int nAsserts = 0;
  int nFail    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 20; i++) begin
      if (dbgState == IDLE) break;
      step();
    end
  endtask

  task automatic runTxn(input logic isFetch, input logic we,
                        input logic [63:0] addr, input logic [63:0] wdata);
    logic        mis, isStore, gotAck;
    logic [63:0] expData, obs;
    int          ifA0, ifV0, dA0, dV0, wr0, waitCyc;
    waitIdle();
    mis     = !isFetch && (addr[2:0] != 3'd0);
    isStore = !isFetch && we && !mis;
    ifA0 = ifAckCnt; ifV0 = ifValidCnt; dA0 = dAckCnt; dV0 = dValidCnt; wr0 = memWrCnt;
    if (isFetch) begin
      expData = addr[2] ? {32'h0, refMem[addr[9:3]][63:32]} : {32'h0, refMem[addr[9:3]][31:0]};
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end else begin
      expData     = refMem[addr[9:3]];
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
    end
    if (!isStore && !mis) exp_q.push_back(expData);
    step();
    gotAck = isFetch ? bus.if_ack : bus.d_ack;
    check1("ack_at_t_plus_1", gotAck, 1'b1);
    check1("d_err_pulse", bus.d_err, mis);
    check1("mem_wr_in_issue", bus.mem_wr, isStore);
    if (!mis) check("mem_addr_aligned", bus.mem_addr, addr & ~64'h7);
    if (isStore) check("mem_wdata", bus.mem_wdata, wdata);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    if (isStore) refMem[addr[9:3]] = wdata;
    if (isStore || mis) begin
      step();
      check1("mem_wr_dropped", bus.mem_wr, 1'b0);
      check("state_idle_after", 64'(dbgState), 64'(IDLE));
      for (int i = 0; i < MEM_LAT + 2; i++) step();
      check("no_d_valid", 64'(dValidCnt - dV0), 64'd0);
      check("mem_wr_pulses", 64'(memWrCnt - wr0), isStore ? 64'd1 : 64'd0);
    end else begin
      waitCyc = 0;
      for (int i = 0; i < MEM_LAT + 4; i++) begin
        step();
        waitCyc++;
        if (isFetch ? bus.if_valid : bus.d_valid) break;
      end
      check("valid_latency", 64'(waitCyc), 64'(MEM_LAT + 1));
      obs = isFetch ? {32'h0, bus.if_rdata} : bus.d_rdata;
      if (exp_q.size() > 0) check("rdata", obs, exp_q.pop_front());
      check("no_mem_wr_on_read", 64'(memWrCnt - wr0), 64'd0);
    end
    if (isFetch) check("no_d_activity", 64'((dAckCnt - dA0) + (dValidCnt - dV0)), 64'd0);
    else         check("no_if_activity", 64'((ifAckCnt - ifA0) + (ifValidCnt - ifV0)), 64'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic expOrder[$];
    logic gotOrder[$];
    int   starve, dualAck, ifV0, kind, word, gap;
    logic [63:0] wd;

    for (int i = 0; i < WORDS; i++) refMem[i] = seedWord(i);
    Reset       = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    step();
    step();

    // reset state
    check("rst_state", 64'(dbgState), 64'(IDLE));
    check("rst_starve", 64'(dbgStarveCnt), 64'd0);
    check1("rst_if_ack", bus.if_ack, 1'b0);
    check1("rst_d_ack", bus.d_ack, 1'b0);
    check1("rst_mem_wr", bus.mem_wr, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
    check("rst_mem_wdata", bus.mem_wdata, 64'd0);
    check("rst_if_rdata", {32'h0, bus.if_rdata}, 64'd0);
    check("rst_d_rdata", bus.d_rdata, 64'd0);
    Reset = 1'b0;
    step();

    // fetch of both halves of a known word
    runTxn(1'b0, 1'b1, 64'h100, 64'hAAAA_BBBB_1111_2222);
    runTxn(1'b1, 1'b0, 64'h104, 64'd0);
    check("fetch_hi_word", {32'h0, bus.if_rdata}, 64'h0000_0000_AAAA_BBBB);
    runTxn(1'b1, 1'b0, 64'h100, 64'd0);
    check("fetch_lo_word", {32'h0, bus.if_rdata}, 64'h0000_0000_1111_2222);

    // store then load of the same doubleword
    runTxn(1'b0, 1'b1, 64'h40, 64'hDEAD_BEEF_0123_4567);
    runTxn(1'b0, 1'b0, 64'h40, 64'd0);
    check("load_back", bus.d_rdata, 64'hDEAD_BEEF_0123_4567);

    // misaligned load and store
    runTxn(1'b0, 1'b0, 64'h43, 64'd0);
    runTxn(1'b0, 1'b1, 64'h4C, 64'h5555_6666_7777_8888);

    // both requesters held: grant order from the priority rule
    waitIdle();
    starve = 0;
    for (int k = 0; k < 10; k++) begin
      if (starve == STARVE_MAX) begin
        expOrder.push_back(1'b1);
        starve = 0;
      end else begin
        expOrder.push_back(1'b0);
        starve = (starve < STARVE_MAX) ? starve + 1 : starve;
      end
    end
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h104;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 64'h40;
    dualAck     = 0;
    for (int c = 0; c < 300 && gotOrder.size() < 10; c++) begin
      step();
      if (bus.if_ack && bus.d_ack) dualAck++;
      if (bus.if_ack)     gotOrder.push_back(1'b1);
      else if (bus.d_ack) gotOrder.push_back(1'b0);
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    check("grant_count", 64'(gotOrder.size()), 64'd10);
    check("single_ack", 64'(dualAck), 64'd0);
    for (int k = 0; k < 10; k++) begin
      check1($sformatf("grant_%0d", k), (k < gotOrder.size()) ? gotOrder[k] : 1'bx, expOrder[k]);
    end

    // random serial traffic against the reference memory
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 3);
      word = $urandom_range(0, WORDS - 1);
      wd   = {$urandom, $urandom};
      case (kind)
        0:       runTxn(1'b1, 1'b0, (64'(word) << 3) | 64'($urandom_range(0, 7)), 64'd0);
        1:       runTxn(1'b0, 1'b0, 64'(word) << 3, 64'd0);
        2:       runTxn(1'b0, 1'b1, 64'(word) << 3, wd);
        default: runTxn(1'b0, 1'($urandom_range(0, 1)),
                        (64'(word) << 3) | 64'($urandom_range(1, 7)), wd);
      endcase
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
    end

    // reset in the second WAIT cycle of a fetch
    waitIdle();
    ifV0        = ifValidCnt;
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h104;
    step();
    check1("rst_fetch_ack", bus.if_ack, 1'b1);
    bus.if_req = 1'b0;
    step();
    step();
    check("rst_in_wait", 64'(dbgState), 64'(WAIT));
    #2 Reset = 1'b1;
    #1;
    check("abort_state", 64'(dbgState), 64'(IDLE));
    check1("abort_if_ack", bus.if_ack, 1'b0);
    check1("abort_if_valid", bus.if_valid, 1'b0);
    check1("abort_d_valid", bus.d_valid, 1'b0);
    check1("abort_mem_wr", bus.mem_wr, 1'b0);
    check("abort_mem_addr", bus.mem_addr, 64'd0);
    check("abort_if_rdata", {32'h0, bus.if_rdata}, 64'd0);
    check("abort_d_rdata", bus.d_rdata, 64'd0);
    step();
    step();
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("no_valid_after_abort", 64'(ifValidCnt - ifV0), 64'd0);

    // reset during a store drops mem_wr at once and the store is lost
    waitIdle();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 64'h48;
    bus.d_wdata = 64'h0BAD_F00D_0BAD_F00D;
    step();
    check1("rst_store_wr", bus.mem_wr, 1'b1);
    #2 Reset = 1'b1;
    #1;
    check1("rst_store_wr_async", bus.mem_wr, 1'b0);
    bus.d_req = 1'b0;
    step();
    Reset = 1'b0;
    step();
    runTxn(1'b0, 1'b0, 64'h48, 64'd0);

    // normal service after reset
    runTxn(1'b1, 1'b0, 64'h104, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 64-bit data memory port between two requesters:
  - instruction fetch (32-bit reads);
  - data load/store (64-bit reads/writes).
- Sits between the control unit's fetch/memory-access steps and the memory, so the processor can run on a unified memory.
- One transaction in flight at a time. Fixed priority: data first, fetch second, with an anti-starvation counter for fetch.

Parameters:
- MEM_LAT, 1, memory read latency in cycles; address in cycle k gives data on mem_rdata in cycle k+MEM_LAT; legal range 1..7.
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  64  fetch byte address; [1:0] ignored
- if_ack  out  1  one-cycle pulse: fetch accepted and issued
- if_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  64  data byte address; must be 8-byte aligned
- d_wdata  in  64  store data
- d_ack  out  1  one-cycle pulse: data request accepted
- d_valid  out  1  one-cycle pulse: d_rdata valid (loads only)
- d_rdata  out  64  loaded doubleword
- d_err  out  1  one-cycle pulse: misaligned data request, not issued
- mem_addr  out  64  memory address
- mem_wdata  out  64  memory write data
- mem_wr  out  1  memory write strobe
- mem_rdata  in  64  memory read data

Behaviour:
- Reset and clocking: one clock, clk. Reset is asynchronous and active-high.
- Reset values: state IDLE; every output 0, including rdata registers, mem_addr, mem_wdata and mem_wr; starve_cnt 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, arbitration on the sampling edge:
  - data wins if d_req=1 and not forced;
  - fetch wins if if_req=1 and either d_req=0 or starve_cnt==STARVE_MAX.
  - Winner's address, we and wdata are latched into internal registers; next state ISSUE.
  - No request: stay in IDLE.
- Misaligned data winner (d_addr[2:0]!=0):
  - d_err and d_ack pulse in the following cycle; memory is not driven; return to IDLE.
  - Counts as a data grant for starve_cnt.
- ISSUE (exactly 1 cycle):
  - mem_addr = latched address with [2:0] forced to 0.
  - Owner's ack pulses.
  - Store: mem_wr=1 and mem_wdata=latched wdata for this cycle only; next state IDLE; no d_valid.
  - Load or fetch: next state WAIT, latency counter = MEM_LAT.
- WAIT:
  - mem_addr is held and the counter decrements.
  - When the counter reaches 1, mem_rdata is captured on that edge:
    - fetch: if_rdata = if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
    - data: d_rdata = mem_rdata.
  - Then go to DONE.
- DONE: owner's valid pulses for 1 cycle; rdata holds until the next capture; next state IDLE.
- Latency: request first seen at edge T gives ack in cycle T+1 and valid in cycle T+2+MEM_LAT. Store occupancy is 2 cycles; read occupancy is MEM_LAT+3 cycles.
- starve_cnt:
  - increments (saturating at STARVE_MAX) on each data grant made while if_req=1;
  - clears on any fetch grant, or when arbitration sees if_req=0.
- Requests that arrive while not in IDLE are ignored until IDLE. Requesters keep req high; dropping req before ack is legal and simply withdraws the request.
- Simultaneous if_req and d_req in IDLE follow the priority rule above; exactly one ack is issued.
- Reset mid-transaction aborts immediately:
  - no ack or valid is emitted;
  - mem_wr drops asynchronously;
  - in-flight read data is discarded.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - owner enum (OWN_IF, OWN_D);
  - ALIGN_MASK constant 64'h7.
- Sub-module mem_arb_select: winner selection, misalignment check and starve_cnt register.
- The top holds the FSM, latency counter, latch registers and the data-return path.

Test Plan:
- Single fetch, MEM_LAT=1, if_addr=0x104, mem word at 0x100 = 64'hAAAA_BBBB_1111_2222 -> if_ack in cycle T+1 with mem_addr=0x100; if_valid in cycle T+3 with if_rdata=32'hAAAA_BBBB.
- Store then load of d_addr=0x40 with d_wdata=64'hDEAD_BEEF_0123_4567 -> mem_wr high for exactly 1 cycle; the following load gives d_valid with the same value and no if_* activity.
- if_req and d_req held high together, STARVE_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Misaligned load d_addr=0x43 -> d_ack and d_err in cycle T+1; mem_wr=0 throughout; no d_valid; state back to IDLE.
- MEM_LAT=3 fetch with Reset asserted in the second WAIT cycle -> all outputs 0 immediately; no if_valid afterwards; the next if_req after Reset is served normally.
